// File: rtl/spi_reg_responder_if.sv
// SPI bus between the RPi (master) and the CPLD register responder (slave).
//   SPI_CLK_IN   : SCK from the master, idle low
//   SPI_MOSI_IN  : master-out data
//   SPI_NSS_IN   : chip select, active low
//   SPI_MISO_OUT : responder data back to the master
//   SPI_MISO_OE  : high while the responder owns the MISO pin
interface spi_reg_responder_if;
    logic SPI_CLK_IN;
    logic SPI_MOSI_IN;
    logic SPI_NSS_IN;
    logic SPI_MISO_OUT;
    logic SPI_MISO_OE;

    modport master (
        output SPI_CLK_IN,
        output SPI_MOSI_IN,
        output SPI_NSS_IN,
        input  SPI_MISO_OUT,
        input  SPI_MISO_OE
    );

    modport slave (
        input  SPI_CLK_IN,
        input  SPI_MOSI_IN,
        input  SPI_NSS_IN,
        output SPI_MISO_OUT,
        output SPI_MISO_OE
    );
endinterface

// File: rtl/spi_reg_responder.sv
// SPI mode-0 register responder. Oversamples the SPI pins on CLK and decodes
// 2-byte frames (command, data) against a small register file plus an ID reg.
//   CLK, RST_N : system clock, async active-low reset
//   spi        : SPI bus (slave modport), MISO with output enable
//   REG_OUT    : register file, reg n at [8n+7:8n]
//   WR_STROBE  : one-CLK pulse on a committed write
//   WR_ADDR    : address of the last committed write
module spi_reg_responder #(
    parameter int unsigned NUM_REGS    = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    spi_reg_responder_if.slave      spi,
    output logic [8*NUM_REGS-1:0]   REG_OUT,
    output logic                    WR_STROBE,
    output logic [6:0]              WR_ADDR
);

    localparam int unsigned IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [6:0]  REG_LIM = 7'(NUM_REGS);
    localparam logic [6:0]  ID_ADDR = 7'h7F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        TAIL = 2'd3
    } state_t;

    // Synchronizers and edge-history flops
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic [SYNC_STAGES-1:0] r_nss_sync;
    logic                   r_sck_hist;
    logic                   r_nss_hist;

    logic w_sck;
    logic w_mosi;
    logic w_nss;
    logic w_rise;
    logic w_fall;
    logic w_nss_fall;
    logic w_nss_rise;

    // Frame state
    state_t                       r_state;
    logic [2:0]                   r_bit_cnt;
    logic [6:0]                   r_rx;
    logic                         r_rw;
    logic [6:0]                   r_addr;
    logic [7:0]                   r_tx;
    logic                         r_first_fall;
    logic                         r_miso;
    logic                         r_oe;
    logic                         r_wr_strobe;
    logic [6:0]                   r_wr_addr;
    logic [NUM_REGS-1:0][7:0]     r_regs;

    logic [7:0] w_rd_val;

    // Input synchronizers; reset to the bus idle levels so no false edge at release
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sck_sync  <= '0;
            r_mosi_sync <= '0;
            r_nss_sync  <= '1;
            r_sck_hist  <= 1'b0;
            r_nss_hist  <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0],  spi.SPI_CLK_IN};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi.SPI_MOSI_IN};
            r_nss_sync  <= {r_nss_sync[SYNC_STAGES-2:0],  spi.SPI_NSS_IN};
            r_sck_hist  <= w_sck;
            r_nss_hist  <= w_nss;
        end
    end

    assign w_sck      = r_sck_sync[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
    assign w_nss      = r_nss_sync[SYNC_STAGES-1];
    assign w_rise     = w_sck & ~r_sck_hist;
    assign w_fall     = ~w_sck & r_sck_hist;
    assign w_nss_fall = ~w_nss & r_nss_hist;
    assign w_nss_rise = w_nss & ~r_nss_hist;

    // Read value for the latched address
    always_comb begin
        w_rd_val = 8'h00;
        if (r_addr < REG_LIM) begin
            w_rd_val = r_regs[IDX_W'(r_addr)];
        end else if (r_addr == ID_ADDR) begin
            w_rd_val = ID_VALUE;
        end
    end

    // Frame FSM; nss_rise overrides everything, including a coincident SCK edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 3'd0;
            r_rx         <= 7'd0;
            r_rw         <= 1'b0;
            r_addr       <= 7'd0;
            r_tx         <= 8'd0;
            r_first_fall <= 1'b0;
            r_miso       <= 1'b0;
            r_oe         <= 1'b0;
            r_wr_strobe  <= 1'b0;
            r_wr_addr    <= 7'd0;
            r_regs       <= '0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_nss_rise) begin
                r_state <= IDLE;
                r_oe    <= 1'b0;
                r_miso  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_miso <= 1'b0;
                        if (w_nss_fall) begin
                            r_state   <= CMD;
                            r_bit_cnt <= 3'd0;
                            r_rx      <= 7'd0;
                            r_oe      <= 1'b1;
                        end
                    end
                    CMD: begin
                        r_miso <= 1'b0;
                        if (w_rise) begin
                            r_rx      <= {r_rx[5:0], w_mosi};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            // 8th bit: r_rx holds bits 7..1 of the command byte
                            if (r_bit_cnt == 3'd7) begin
                                r_rw         <= r_rx[6];
                                r_addr       <= {r_rx[5:0], w_mosi};
                                r_first_fall <= 1'b1;
                                r_state      <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        if (w_rise) begin
                            r_rx      <= {r_rx[5:0], w_mosi};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_state <= TAIL;
                                r_miso  <= 1'b0;
                                if (!r_rw && (r_addr < REG_LIM)) begin
                                    r_regs[IDX_W'(r_addr)] <= {r_rx, w_mosi};
                                    r_wr_strobe            <= 1'b1;
                                    r_wr_addr              <= r_addr;
                                end
                            end
                        end else if (w_fall && r_rw) begin
                            // First fall loads the read byte and presents its MSB
                            if (r_first_fall) begin
                                r_miso       <= w_rd_val[7];
                                r_tx         <= {w_rd_val[6:0], 1'b0};
                                r_first_fall <= 1'b0;
                            end else begin
                                r_miso <= r_tx[7];
                                r_tx   <= {r_tx[6:0], 1'b0};
                            end
                        end
                    end
                    TAIL: begin
                        r_miso <= 1'b0;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_miso  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign spi.SPI_MISO_OUT = r_miso;
    assign spi.SPI_MISO_OE  = r_oe;
    assign REG_OUT          = r_regs;
    assign WR_STROBE        = r_wr_strobe;
    assign WR_ADDR          = r_wr_addr;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Testbench for spi_reg_responder: SPI master driving frames at the minimum
// SCK half-period, with a scoreboard of expected MISO bytes and a register model.
module tb_spi_reg_responder;

    localparam int unsigned NUM_REGS    = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int          H           = SYNC_STAGES + 2;

    typedef struct {
        int         idx;
        logic [7:0] val;
    } exp_t;

    logic                   clk;
    logic                   rst_n;
    logic [8*NUM_REGS-1:0]  reg_out;
    logic                   wr_strobe;
    logic [6:0]             wr_addr;

    int n_cmp;
    int n_err;
    int strobe_cnt;

    logic [7:0] m_regs [NUM_REGS];
    logic [6:0] m_wr_addr;
    exp_t       exp_q[$];

    spi_reg_responder_if spi_if();

    spi_reg_responder #(
        .NUM_REGS    (NUM_REGS),
        .SYNC_STAGES (SYNC_STAGES),
        .ID_VALUE    (8'hA5)
    ) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .spi       (spi_if.slave),
        .REG_OUT   (reg_out),
        .WR_STROBE (wr_strobe),
        .WR_ADDR   (wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial strobe_cnt = 0;
    always @(posedge clk) begin
        if (wr_strobe === 1'b1) strobe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] model_rd(input logic [6:0] a);
        if (a < 7'(NUM_REGS)) return m_regs[int'(a)];
        else if (a == 7'h7F)  return 8'hA5;
        else                  return 8'h00;
    endfunction

    function automatic logic [8*NUM_REGS-1:0] model_pack();
        logic [8*NUM_REGS-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_REGS; i++) p[8*i +: 8] = m_regs[i];
        return p;
    endfunction

    // Drive one frame of nbits (MSB-first from tx[31]) and score the result
    task automatic spi_frame(input logic [31:0] tx, input int nbits);
        logic [31:0] rx;
        logic [7:0]  cmd;
        int          s0;
        int          exp_strobes;
        exp_t        e;
        rx          = '0;
        cmd         = tx[31:24];
        exp_strobes = 0;

        if (nbits >= 8) exp_q.push_back('{idx: 0, val: 8'h00});
        if (nbits >= 16 && cmd[7]) exp_q.push_back('{idx: 1, val: model_rd(cmd[6:0])});
        for (int b = 2; b < nbits / 8; b++) exp_q.push_back('{idx: b, val: 8'h00});
        if (nbits >= 16 && !cmd[7] && (cmd[6:0] < 7'(NUM_REGS))) begin
            m_regs[int'(cmd[6:0])] = tx[23:16];
            m_wr_addr              = cmd[6:0];
            exp_strobes            = 1;
        end

        s0 = strobe_cnt;
        spi_if.SPI_NSS_IN = 1'b0;
        wait_clk(H);
        for (int i = 0; i < nbits; i++) begin
            spi_if.SPI_MOSI_IN = tx[31-i];
            wait_clk(H);
            rx[31-i] = spi_if.SPI_MISO_OUT;
            if (i == 0) check("miso_oe_active", 32'(spi_if.SPI_MISO_OE), 32'd1);
            spi_if.SPI_CLK_IN = 1'b1;
            wait_clk(H);
            spi_if.SPI_CLK_IN = 1'b0;
        end
        wait_clk(H);
        spi_if.SPI_NSS_IN = 1'b1;
        wait_clk(2 * H);

        check("miso_oe_idle", 32'(spi_if.SPI_MISO_OE), 32'd0);
        check("strobe_count", 32'(strobe_cnt - s0), 32'(exp_strobes));
        check("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
        check("reg_out", 32'(reg_out), 32'(model_pack()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("miso_byte%0d", e.idx), 32'(rx[31-8*e.idx -: 8]), 32'(e.val));
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_wr_addr          = 7'd0;
        rst_n              = 1'b0;
        spi_if.SPI_CLK_IN  = 1'b0;
        spi_if.SPI_MOSI_IN = 1'b0;
        spi_if.SPI_NSS_IN  = 1'b1;
        wait_clk(3);
        check("rst_reg_out",   32'(reg_out), 32'd0);
        check("rst_oe",        32'(spi_if.SPI_MISO_OE), 32'd0);
        check("rst_miso",      32'(spi_if.SPI_MISO_OUT), 32'd0);
        check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        check("rst_wr_addr",   32'(wr_addr), 32'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // Write then readback
        spi_frame(32'h013C_0000, 16);
        spi_frame(32'h8100_0000, 16);
        // ID, unmapped read, dropped writes
        spi_frame(32'hFF00_0000, 16);
        spi_frame(32'h8500_0000, 16);
        spi_frame(32'h0577_0000, 16);
        spi_frame(32'h7F12_0000, 16);
        // Aborted write after 12 bits, then full frames still work
        spi_frame(32'h0255_0000, 12);
        spi_frame(32'h8200_0000, 16);
        spi_frame(32'h0266_0000, 16);
        spi_frame(32'h8200_0000, 16);
        // Long frame: only the first data byte commits
        spi_frame(32'h0011_2233, 32);
        spi_frame(32'h8000_0000, 32);
        // Back-to-back frames across all registers
        for (int r = 0; r < NUM_REGS; r++) begin
            logic [31:0] w;
            w = 32'h0000_0000;
            w[30:24] = 7'(r);
            w[23:16] = 8'(8'hC0 + 8'(r * 17));
            spi_frame(w, 16);
        end
        for (int r = 0; r < NUM_REGS; r++) begin
            logic [31:0] w;
            w = 32'h8000_0000;
            w[30:24] = 7'(r);
            spi_frame(w, 16);
        end

        // Reset asserted mid-frame
        spi_if.SPI_NSS_IN = 1'b0;
        wait_clk(H);
        for (int i = 0; i < 5; i++) begin
            spi_if.SPI_MOSI_IN = 1'b1;
            wait_clk(H);
            spi_if.SPI_CLK_IN = 1'b1;
            wait_clk(H);
            spi_if.SPI_CLK_IN = 1'b0;
        end
        rst_n = 1'b0;
        wait_clk(2);
        spi_if.SPI_NSS_IN  = 1'b1;
        spi_if.SPI_MOSI_IN = 1'b0;
        check("midrst_reg_out", 32'(reg_out), 32'd0);
        check("midrst_oe",      32'(spi_if.SPI_MISO_OE), 32'd0);
        check("midrst_strobe",  32'(wr_strobe), 32'd0);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_wr_addr = 7'd0;
        check("postrst_reg_out", 32'(reg_out), 32'd0);
        check("postrst_oe",      32'(spi_if.SPI_MISO_OE), 32'd0);
        check("postrst_wr_addr", 32'(wr_addr), 32'd0);
        spi_frame(32'h8100_0000, 16);
        spi_frame(32'h035A_0000, 16);
        spi_frame(32'h8300_0000, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
- SPI mode-0 responder (slave) inside the CPLD. It terminates the RPi SPI bus that is otherwise forwarded pin-to-pin.
- Oversamples SPI_CLK / SPI_MOSI / SPI_NSS on the CPLD system clock. Decodes 2-byte frames: command byte, then data byte.
- Services a small local register file and a read-only ID register.
- Drives MISO back to the RPi, with an output enable so the pin can share the bus with the forwarded MISO path.

Parameters:
- NUM_REGS, 4, number of read/write 8-bit registers at addresses 0..NUM_REGS-1 (max 16).
- SYNC_STAGES, 2, flip-flop stages on each asynchronous SPI input (min 2).
- ID_VALUE, 8'hA5, constant returned on a read of address 7'h7F.

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- SPI_CLK_IN  input  1  SPI SCK from the RPi; idle low.
- SPI_MOSI_IN  input  1  SPI MOSI from the RPi.
- SPI_NSS_IN  input  1  chip select from the RPi, active-low.
- SPI_MISO_OUT  output  1  responder data to the RPi.
- SPI_MISO_OE  output  1  high while this block owns MISO.
- REG_OUT  output  8*NUM_REGS  register file contents; reg n is at bits [8n+7:8n].
- WR_STROBE  output  1  one-CLK pulse when a register write commits.
- WR_ADDR  output  7  address of the last committed write.

Behaviour:
- Reset (RST_N low, any time, asynchronous):
  - all registers, SPI_MISO_OUT, SPI_MISO_OE, WR_STROBE and WR_ADDR go to 0.
  - FSM goes to IDLE; synchronizer flops reset to the idle levels SCK=0, NSS=1.
- Synchronization and edge detection:
  - each SPI input passes through SYNC_STAGES flops, then one history flop for edge detection.
  - rise/fall/nss_fall/nss_rise are single-CLK pulses.
  - Timing requirement: SCK high and low times are each ≥ SYNC_STAGES+2 CLK periods. Behaviour is undefined if this is violated.
- FSM states IDLE, CMD, DATA, TAIL:
  - IDLE: on nss_fall → CMD; bit counter = 0, rx shift = 0.
  - CMD: each SCK rise shifts MOSI into rx LSB, MSB first.
    - After the 8th rise, latch rw = rx[7] (1 = read, 0 = write) and addr = rx[6:0], then → DATA.
  - DATA, read: on the first SCK fall after entering DATA, load the tx shift register with the read value. The MSB is on MISO before the 9th rise.
    - Each following fall shifts left.
    - After the 16th rise → TAIL.
  - DATA, write: the 8 MOSI bits shift in on rises 9..16. On the CLK after the 16th rise:
    - if addr < NUM_REGS, the register takes the data byte, WR_STROBE pulses for exactly 1 CLK and WR_ADDR = addr.
    - otherwise the write is silently dropped: no strobe, no WR_ADDR change.
    - Then → TAIL.
  - TAIL: further SCK edges are ignored, MISO = 0, no writes. Only nss_rise leaves this state.
  - nss_rise in any state → IDLE, same CLK. A write commits only if all 16 bits were received before nss_rise; a truncated frame changes nothing.
- Read value:
  - addr < NUM_REGS → that register.
  - addr = 7'h7F → ID_VALUE.
  - any other address → 8'h00.
  - A write to 7'h7F is dropped.
- MISO:
  - SPI_MISO_OE = 1 from the CLK after nss_fall until the CLK after nss_rise; otherwise 0.
  - SPI_MISO_OUT = 0 during CMD, TAIL and IDLE.
- Simultaneous events:
  - nss_rise in the same CLK as a rise edge: nss_rise wins and the edge is discarded.
  - nss_fall while not in IDLE cannot occur, because nss_rise always precedes it.
- Registers change only on a committed write or on reset.

Test Plan:
- Reset: hold RST_N low mid-frame, release → REG_OUT=0, MISO_OE=0, WR_STROBE=0; the next frame decodes normally.
- Write then readback:
  - frame 0x01,0x3C → REG_OUT[15:8]=0x3C, WR_STROBE one pulse, WR_ADDR=1.
  - frame 0x81,xx → MISO byte 2 = 0x3C.
- ID and unmapped addresses:
  - read of 0xFF → 0xA5.
  - read of 0x85 → 0x00.
  - write 0x05,0x77 → no strobe, REG_OUT unchanged.
- Abort: write frame 0x02,0x55 with NSS raised after 12 bits → no strobe, reg 2 unchanged, FSM back in IDLE; the next full frame works.
- Long frame: 0x00,0x11,0x22,0x33 → reg 0 = 0x11, only one strobe, MISO = 0 for bytes 3-4.
- Timing margin: SCK high/low at exactly SYNC_STAGES+2 CLK, back-to-back frames with 1 SCK-period NSS gap → every byte decoded correctly.
